// File: rtl/sdr_bist_pkg.sv
// Shared types and constants for the SDRAM Wishbone BIST engine.
// Holds the sequencer states, mode encodings, burst CTI codes and the data LFSR.
package sdr_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_GAP,
      RD,
      RD_GAP,
      FIN
   } state_t;

   localparam logic [1:0] MODE_INTL = 2'b00;
   localparam logic [1:0] MODE_WO   = 2'b01;
   localparam logic [1:0] MODE_RO   = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/sdr_bist_dfifo.sv
// Burst-descriptor FIFO: records {start address, length} of each written burst
// so the read group can replay the same bursts in order. Head is show-ahead.
module sdr_bist_dfifo #(
   parameter int DEPTH = 4,
   parameter int W     = 38
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW:0]  wr_ptr;
   logic [PW:0]  rd_ptr;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop  && !empty) rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push && !full) mem[wr_ptr[PW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[PW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/sdr_wb_bist.sv
// Wishbone burst BIST master: writes LFSR patterns in incrementing bursts and
// reads them back, counting mismatches and capturing the first failing address.
//
// state  | meaning
// IDLE   | waiting for start
// WR     | write burst on the bus
// WR_GAP | one idle cycle after a write burst; picks next burst
// RD     | read burst on the bus, data compared on ack
// RD_GAP | one idle cycle after a read burst; picks next burst
// FIN    | done pulse, then back to IDLE
module sdr_wb_bist
   import sdr_bist_pkg::*;
#(
   parameter int DW    = 32,
   parameter int AW    = 30,
   parameter int DEPTH = 4,
   parameter int BLW   = 8
) (
   input  logic            wb_clk_i,
   input  logic            wb_resetn,
   input  logic            start,
   input  logic [1:0]      cfg_mode,
   input  logic [AW-1:0]   cfg_base_addr,
   input  logic [AW-1:0]   cfg_addr_step,
   input  logic [BLW-1:0]  cfg_burst_len,
   input  logic [15:0]     cfg_num_bursts,
   input  logic [31:0]     cfg_seed,
   output logic            busy,
   output logic            done,
   output logic [15:0]     err_cnt,
   output logic [AW-1:0]   first_err_addr,
   output logic            first_err_vld,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_addr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic [2:0]      wb_cti_o,
   input  logic            wb_ack_i,
   input  logic [DW-1:0]   wb_dat_i
);

   state_t          state, state_nx;
   logic [1:0]      mode;
   logic [AW-1:0]   step, addr, wr_base, rd_base;
   logic [BLW-1:0]  len, cur_len, beat, len_in;
   logic [15:0]     wr_left, rd_left;
   logic [31:0]     wr_lfsr, rd_lfsr, seed_in;
   logic            last_beat, push, pop, full, empty;
   logic [AW+BLW-1:0] fifo_dout;

   assign len_in    = (cfg_burst_len == '0) ? BLW'(1) : cfg_burst_len;
   assign seed_in   = (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
   assign last_beat = (beat == cur_len - BLW'(1));
   assign push      = (mode == MODE_INTL) && (state == WR) && wb_ack_i && last_beat;
   assign pop       = (mode == MODE_INTL) && (state == RD) && wb_ack_i && last_beat;

   sdr_bist_dfifo #(.DEPTH(DEPTH), .W(AW+BLW)) u_dfifo (
      .clk_sys (wb_clk_i),
      .rst_b   (wb_resetn),
      .push    (push),
      .pop     (pop),
      .din     ({wr_base, cur_len}),
      .dout    (fifo_dout),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
      if (!wb_resetn) state <= IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (start) state_nx = (cfg_num_bursts == 16'd0) ? FIN :
                                       (cfg_mode == MODE_RO) ? RD : WR;
         WR:     if (wb_ack_i && last_beat)
                    state_nx = (mode == MODE_WO && wr_left == 16'd1) ? FIN : WR_GAP;
         // a full FIFO or no writes left forces the read group
         WR_GAP: state_nx = (mode == MODE_INTL && (full || wr_left == 16'd0)) ? RD : WR;
         RD:     if (wb_ack_i && last_beat) state_nx = (rd_left == 16'd1) ? FIN : RD_GAP;
         RD_GAP: state_nx = (mode == MODE_INTL && empty) ? WR : RD;
         FIN:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
      if (!wb_resetn) begin
         mode <= MODE_INTL;  step <= '0;    len <= '0;     cur_len <= '0;
         beat <= '0;         addr <= '0;    wr_base <= '0; rd_base <= '0;
         wr_left <= '0;      rd_left <= '0;
         wr_lfsr <= 32'h1;   rd_lfsr <= 32'h1;
         err_cnt <= '0;      first_err_addr <= '0; first_err_vld <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               mode    <= (cfg_mode == MODE_RSVD) ? MODE_INTL : cfg_mode;
               step    <= cfg_addr_step;
               len     <= len_in;
               cur_len <= len_in;
               beat    <= '0;
               addr    <= cfg_base_addr;
               wr_base <= cfg_base_addr;
               rd_base <= cfg_base_addr;
               wr_left <= cfg_num_bursts;
               rd_left <= cfg_num_bursts;
               wr_lfsr <= seed_in;
               rd_lfsr <= seed_in;
               err_cnt <= '0;
               first_err_vld <= 1'b0;
            end
            WR: if (wb_ack_i) begin
               wr_lfsr <= lfsr_next(wr_lfsr);
               if (last_beat) begin
                  beat    <= '0;
                  wr_base <= wr_base + step;
                  wr_left <= wr_left - 16'd1;
               end else begin
                  beat <= beat + BLW'(1);
                  addr <= addr + AW'(1);
               end
            end
            RD: if (wb_ack_i) begin
               rd_lfsr <= lfsr_next(rd_lfsr);
               if (wb_dat_i != {(DW/32){rd_lfsr}}) begin
                  if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                  if (!first_err_vld) begin
                     first_err_addr <= addr;
                     first_err_vld  <= 1'b1;
                  end
               end
               if (last_beat) begin
                  beat    <= '0;
                  rd_base <= rd_base + step;
                  rd_left <= rd_left - 16'd1;
               end else begin
                  beat <= beat + BLW'(1);
                  addr <= addr + AW'(1);
               end
            end
            WR_GAP, RD_GAP: begin
               if (state_nx == WR) begin
                  addr    <= wr_base;
                  cur_len <= len;
               end else if (mode == MODE_INTL) begin
                  addr    <= fifo_dout[AW+BLW-1:BLW];
                  cur_len <= fifo_dout[BLW-1:0];
               end else begin
                  addr    <= rd_base;
                  cur_len <= len;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == FIN);
   assign wb_cyc_o  = (state == WR) || (state == RD);
   assign wb_stb_o  = wb_cyc_o;
   assign wb_we_o   = (state == WR);
   assign wb_addr_o = wb_cyc_o ? addr : '0;
   assign wb_dat_o  = wb_we_o ? {(DW/32){wr_lfsr}} : '0;
   assign wb_sel_o  = {(DW/8){wb_cyc_o}};
   assign wb_cti_o  = !wb_cyc_o ? CTI_CLASSIC : (last_beat ? CTI_EOB : CTI_INCR);

endmodule

// File: tb/tb_sdr_wb_bist.sv
// Bench for sdr_wb_bist: memory-model slave with random wait states, expected
// bus beats queued from an independent sequencing model and compared per beat.
module tb_sdr_wb_bist;
   localparam int DW = 32, AW = 30, DEPTH = 4, BLW = 8;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          we;
      logic [31:0]   dat;
      logic [2:0]    cti;
   } beat_t;

   logic            wb_clk_i = 1'b0;
   logic            wb_resetn;
   logic            start;
   logic [1:0]      cfg_mode;
   logic [AW-1:0]   cfg_base_addr, cfg_addr_step;
   logic [BLW-1:0]  cfg_burst_len;
   logic [15:0]     cfg_num_bursts;
   logic [31:0]     cfg_seed;
   logic            busy, done, first_err_vld;
   logic [15:0]     err_cnt;
   logic [AW-1:0]   first_err_addr;
   logic            wb_cyc_o, wb_stb_o, wb_we_o;
   logic [AW-1:0]   wb_addr_o;
   logic [DW-1:0]   wb_dat_o;
   logic [DW/8-1:0] wb_sel_o;
   logic [2:0]      wb_cti_o;
   logic            wb_ack_i;
   logic [DW-1:0]   wb_dat_i;

   always #5 wb_clk_i = ~wb_clk_i;

   sdr_wb_bist #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .BLW(BLW)) dut (
      .wb_clk_i(wb_clk_i), .wb_resetn(wb_resetn), .start(start), .cfg_mode(cfg_mode),
      .cfg_base_addr(cfg_base_addr), .cfg_addr_step(cfg_addr_step),
      .cfg_burst_len(cfg_burst_len), .cfg_num_bursts(cfg_num_bursts), .cfg_seed(cfg_seed),
      .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
      .first_err_vld(first_err_vld), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
   );

   beat_t       exp_q[$], obs_q[$];
   logic [31:0] mem [logic [AW-1:0]];
   int n_chk = 0, n_pass = 0;
   int max_wait = 0, wait_left = 0, corrupt_rd = -1, rd_seen = 0;
   int stab_viol = 0, done_cnt = 0, cyc_cycles = 0;
   int gap_run = 0, gap_min = 1000, gap_max = 0;
   bit pend = 0;
   beat_t p_beat;

   // slave + monitor: acks after a random wait, records acked beats and checks hold-while-unacked
   initial begin
      beat_t o;
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      forever begin
         @(negedge wb_clk_i);
         if (!wb_resetn) begin
            wb_ack_i = 1'b0;
            pend = 0;
            gap_run = 0;
         end else begin
            o.addr = wb_addr_o; o.we = wb_we_o; o.dat = wb_dat_o; o.cti = wb_cti_o;
            if (pend && (!(wb_cyc_o && wb_stb_o) || o !== p_beat || wb_sel_o !== 4'hF))
               stab_viol++;
            if (done) done_cnt++;
            if (wb_cyc_o) cyc_cycles++;
            if (busy && !wb_cyc_o) gap_run++;
            else if (wb_cyc_o && gap_run > 0) begin
               if (gap_run < gap_min) gap_min = gap_run;
               if (gap_run > gap_max) gap_max = gap_run;
               gap_run = 0;
            end else if (!busy) gap_run = 0;
            if (wb_cyc_o && wb_stb_o) begin
               if (wait_left == 0) begin
                  wb_ack_i = 1'b1;
                  obs_q.push_back(o);
                  if (wb_we_o) mem[wb_addr_o] = wb_dat_o;
                  else begin
                     wb_dat_i = mem.exists(wb_addr_o) ? mem[wb_addr_o] : 32'h0;
                     if (rd_seen == corrupt_rd) wb_dat_i = wb_dat_i ^ 32'h0000_0100;
                     rd_seen++;
                  end
                  wait_left = $urandom_range(max_wait, 0);
                  pend = 0;
               end else begin
                  wb_ack_i = 1'b0;
                  wait_left--;
                  pend = 1;
                  p_beat = o;
               end
            end else begin
               wb_ack_i = 1'b0;
               pend = 0;
            end
         end
      end
   end

   function automatic logic [31:0] model_lfsr(input logic [31:0] s);
      logic fb;
      fb = s[0];
      s = s >> 1;
      if (fb) s = s ^ 32'h8020_0003;
      return s;
   endfunction

   task automatic expect_run(input logic [1:0] mode, input logic [AW-1:0] base, step,
                             input int len, input int nb, input logic [31:0] seed);
      logic [31:0] wl, rl;
      int l, g, dw;
      beat_t e;
      if (mode == 2'b11) mode = 2'b00;
      l  = (len == 0) ? 1 : len;
      wl = (seed == 0) ? 32'h1 : seed;
      rl = wl;
      dw = 0;
      while (dw < nb) begin
         g = (mode == 2'b00) ? (((nb - dw) < DEPTH) ? nb - dw : DEPTH) : nb;
         if (mode != 2'b10)
            for (int b = dw; b < dw + g; b++)
               for (int i = 0; i < l; i++) begin
                  e.addr = base + step * AW'(b) + AW'(i);
                  e.we = 1'b1; e.dat = wl; e.cti = (i == l - 1) ? 3'b111 : 3'b010;
                  exp_q.push_back(e);
                  wl = model_lfsr(wl);
               end
         if (mode != 2'b01)
            for (int b = dw; b < dw + g; b++)
               for (int i = 0; i < l; i++) begin
                  e.addr = base + step * AW'(b) + AW'(i);
                  e.we = 1'b0; e.dat = rl; e.cti = (i == l - 1) ? 3'b111 : 3'b010;
                  exp_q.push_back(e);
                  rl = model_lfsr(rl);
               end
         dw += g;
      end
   endtask

   task automatic pulse_start(input logic [1:0] mode, input logic [AW-1:0] base, step,
                              input logic [BLW-1:0] len, input logic [15:0] nb,
                              input logic [31:0] seed);
      @(negedge wb_clk_i);
      cfg_mode = mode; cfg_base_addr = base; cfg_addr_step = step;
      cfg_burst_len = len; cfg_num_bursts = nb; cfg_seed = seed;
      start = 1'b1;
      @(negedge wb_clk_i);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit to);
      to = 1'b1;
      for (int c = 0; c < limit; c++) begin
         @(negedge wb_clk_i);
         if (done) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic prep(input int mw, input int crd);
      max_wait = mw; corrupt_rd = crd; rd_seen = 0; stab_viol = 0;
      gap_min = 1000; gap_max = 0;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset();
      wb_resetn = 1'b0; start = 1'b0;
      cfg_mode = '0; cfg_base_addr = '0; cfg_addr_step = '0;
      cfg_burst_len = '0; cfg_num_bursts = '0; cfg_seed = '0;
      repeat (3) @(negedge wb_clk_i);
      n_chk++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o} !== '0) begin
         $display("FAIL reset_bus: cyc=%b addr=%h dat=%h sel=%h cti=%b, want all zero",
                  wb_cyc_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o);
      end else n_pass++;
      n_chk++;
      if ({busy, done, first_err_vld, err_cnt, first_err_addr} !== '0) begin
         $display("FAIL reset_status: busy=%b done=%b vld=%b err=%0d fea=%h, want zero",
                  busy, done, first_err_vld, err_cnt, first_err_addr);
      end else n_pass++;
      wb_resetn = 1'b1;
      repeat (2) @(negedge wb_clk_i);
      n_chk++;
      if ({busy, wb_cyc_o} !== 2'b00) begin
         $display("FAIL reset_idle: busy=%b cyc=%b, want 0 0", busy, wb_cyc_o);
      end else n_pass++;
   endtask

   task automatic test_interleaved();
      bit to; int d0; beat_t e, o;
      prep(0, -1);
      d0 = done_cnt;
      expect_run(2'b00, 30'h10000, 30'h100, 4, 2, 32'h1);
      pulse_start(2'b00, 30'h10000, 30'h100, 8'd4, 16'd2, 32'h1);
      wait_done(500, to);
      repeat (3) @(negedge wb_clk_i);
      n_chk++;
      if (to !== 1'b0) $display("FAIL ilv_timeout: done not seen, want done"); else n_pass++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_chk++;
         if (o.addr !== e.addr || o.we !== e.we || o.cti !== e.cti || (e.we && o.dat !== e.dat))
            $display("FAIL ilv_beat: got a=%h we=%b d=%h cti=%b, want a=%h we=%b d=%h cti=%b",
                     o.addr, o.we, o.dat, o.cti, e.addr, e.we, e.dat, e.cti);
         else n_pass++;
      end
      n_chk++;
      if (obs_q.size() !== 0) $display("FAIL ilv_extra: %0d extra beats, want 0", obs_q.size());
      else n_pass++;
      n_chk++;
      if (err_cnt !== 16'd0) $display("FAIL ilv_err: err_cnt=%0d, want 0", err_cnt); else n_pass++;
      n_chk++;
      if (done_cnt - d0 !== 1) $display("FAIL ilv_done: %0d pulses, want 1", done_cnt - d0);
      else n_pass++;
      n_chk++;
      if (gap_min !== 1 || gap_max !== 1)
         $display("FAIL ilv_gap: gap min=%0d max=%0d, want 1 1", gap_min, gap_max);
      else n_pass++;
   endtask

   task automatic test_groups();
      bit to; beat_t e, o;
      prep(1, -1);
      expect_run(2'b00, 30'h2000, 30'h10, 2, 10, 32'h1234);
      pulse_start(2'b00, 30'h2000, 30'h10, 8'd2, 16'd10, 32'h1234);
      wait_done(2000, to);
      n_chk++;
      if (to !== 1'b0) $display("FAIL grp_timeout: done not seen, want done"); else n_pass++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_chk++;
         if (o.addr !== e.addr || o.we !== e.we || o.cti !== e.cti || (e.we && o.dat !== e.dat))
            $display("FAIL grp_beat: got a=%h we=%b d=%h cti=%b, want a=%h we=%b d=%h cti=%b",
                     o.addr, o.we, o.dat, o.cti, e.addr, e.we, e.dat, e.cti);
         else n_pass++;
      end
      n_chk++;
      if (obs_q.size() !== 0 || err_cnt !== 16'd0)
         $display("FAIL grp_end: extra=%0d err_cnt=%0d, want 0 0", obs_q.size(), err_cnt);
      else n_pass++;
      n_chk++;
      if (gap_min !== 1 || gap_max !== 1)
         $display("FAIL grp_gap: gap min=%0d max=%0d, want 1 1", gap_min, gap_max);
      else n_pass++;
   endtask

   task automatic test_corrupt();
      bit to;
      prep(0, 2);
      pulse_start(2'b00, 30'h40000, 30'h100, 8'd5, 16'd1, 32'h77);
      wait_done(500, to);
      n_chk++;
      if (to !== 1'b0) $display("FAIL cor_timeout: done not seen, want done"); else n_pass++;
      n_chk++;
      if (err_cnt !== 16'd1) $display("FAIL cor_err: err_cnt=%0d, want 1", err_cnt); else n_pass++;
      n_chk++;
      if (first_err_addr !== 30'h40002 || first_err_vld !== 1'b1)
         $display("FAIL cor_first: addr=%h vld=%b, want 40002 1", first_err_addr, first_err_vld);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit to1, to2; beat_t e, o;
      prep(7, -1);
      expect_run(2'b01, 30'h100, 30'h40, 64, 3, 32'hACE1);
      expect_run(2'b10, 30'h100, 30'h40, 64, 3, 32'hACE1);
      pulse_start(2'b01, 30'h100, 30'h40, 8'd64, 16'd3, 32'hACE1);
      wait_done(10000, to1);
      pulse_start(2'b10, 30'h100, 30'h40, 8'd64, 16'd3, 32'hACE1);
      wait_done(10000, to2);
      n_chk++;
      if ({to1, to2} !== 2'b00) $display("FAIL b2b_timeout: to=%b%b, want 00", to1, to2);
      else n_pass++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_chk++;
         if (o.addr !== e.addr || o.we !== e.we || o.cti !== e.cti || (e.we && o.dat !== e.dat))
            $display("FAIL b2b_beat: got a=%h we=%b d=%h cti=%b, want a=%h we=%b d=%h cti=%b",
                     o.addr, o.we, o.dat, o.cti, e.addr, e.we, e.dat, e.cti);
         else n_pass++;
      end
      n_chk++;
      if (err_cnt !== 16'd0 || first_err_vld !== 1'b0)
         $display("FAIL b2b_err: err_cnt=%0d vld=%b, want 0 0", err_cnt, first_err_vld);
      else n_pass++;
      n_chk++;
      if (stab_viol !== 0) $display("FAIL b2b_stable: %0d unacked changes, want 0", stab_viol);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit to; int c; beat_t e, o;
      prep(0, -1);
      pulse_start(2'b01, 30'h800, 30'h10, 8'd8, 16'd1, 32'h5A5A);
      c = 0;
      while (obs_q.size() < 3 && c < 100) begin
         @(negedge wb_clk_i);
         c++;
      end
      #1 wb_resetn = 1'b0;
      #1;
      n_chk++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o, busy} !== '0 || c >= 100)
         $display("FAIL rst_mid: cyc=%b addr=%h dat=%h busy=%b wait=%0d, want all zero",
                  wb_cyc_o, wb_addr_o, wb_dat_o, busy, c);
      else n_pass++;
      @(negedge wb_clk_i);
      wb_resetn = 1'b1;
      prep(0, -1);
      expect_run(2'b00, 30'h800, 30'h10, 8, 1, 32'h5A5A);
      pulse_start(2'b00, 30'h800, 30'h10, 8'd8, 16'd1, 32'h5A5A);
      wait_done(500, to);
      n_chk++;
      if (to !== 1'b0) $display("FAIL rst_timeout: done not seen, want done"); else n_pass++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_chk++;
         if (o.addr !== e.addr || o.we !== e.we || o.cti !== e.cti || (e.we && o.dat !== e.dat))
            $display("FAIL rst_beat: got a=%h we=%b d=%h cti=%b, want a=%h we=%b d=%h cti=%b",
                     o.addr, o.we, o.dat, o.cti, e.addr, e.we, e.dat, e.cti);
         else n_pass++;
      end
      n_chk++;
      if (err_cnt !== 16'd0) $display("FAIL rst_err: err_cnt=%0d, want 0", err_cnt); else n_pass++;
   endtask

   task automatic test_zero_and_ignore();
      bit to; int d0, c0; beat_t e, o;
      prep(2, -1);
      d0 = done_cnt;
      c0 = cyc_cycles;
      pulse_start(2'b00, 30'h9000, 30'h10, 8'd4, 16'd0, 32'h1);
      n_chk++;
      if (done !== 1'b1) $display("FAIL zero_done: done=%b, want 1", done); else n_pass++;
      @(negedge wb_clk_i);
      n_chk++;
      if ({done, busy} !== 2'b00) $display("FAIL zero_idle: done=%b busy=%b, want 0 0", done, busy);
      else n_pass++;
      n_chk++;
      if (cyc_cycles !== c0 || done_cnt - d0 !== 1)
         $display("FAIL zero_bus: cyc cycles=%0d pulses=%0d, want 0 1", cyc_cycles - c0, done_cnt - d0);
      else n_pass++;
      // reserved mode runs interleaved; zero seed becomes 1; second start is ignored while busy
      d0 = done_cnt;
      expect_run(2'b11, 30'h3000, 30'h20, 3, 2, 32'h0);
      pulse_start(2'b11, 30'h3000, 30'h20, 8'd3, 16'd2, 32'h0);
      repeat (3) @(negedge wb_clk_i);
      pulse_start(2'b01, 30'h5000, 30'h8, 8'd7, 16'd5, 32'h99);
      wait_done(1000, to);
      repeat (20) @(negedge wb_clk_i);
      n_chk++;
      if (to !== 1'b0 || busy !== 1'b0 || done_cnt - d0 !== 1)
         $display("FAIL ign_done: to=%b busy=%b pulses=%0d, want 0 0 1", to, busy, done_cnt - d0);
      else n_pass++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_chk++;
         if (o.addr !== e.addr || o.we !== e.we || o.cti !== e.cti || (e.we && o.dat !== e.dat))
            $display("FAIL ign_beat: got a=%h we=%b d=%h cti=%b, want a=%h we=%b d=%h cti=%b",
                     o.addr, o.we, o.dat, o.cti, e.addr, e.we, e.dat, e.cti);
         else n_pass++;
      end
      n_chk++;
      if (obs_q.size() !== 0 || err_cnt !== 16'd0)
         $display("FAIL ign_end: extra=%0d err_cnt=%0d, want 0 0", obs_q.size(), err_cnt);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_interleaved();
      test_groups();
      test_corrupt();
      test_back_to_back();
      test_reset_mid();
      test_zero_and_ignore();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
